// File: rtl/x_req_arbiter.sv
// x_req_arbiter: shares one memory read port among NUM_PE request queues
// with round-robin issue and in-order response routing by tag.
module x_req_arbiter #(
    parameter int NUM_PE                = 4,
    parameter int LOG2_NUM_PE           = 2,
    parameter int REQ_BUF_DEPTH         = 8,
    parameter int REQ_ALMOST_FULL_SLACK = 4,
    parameter int TAG_FIFO_DEPTH        = 512
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PE-1:0]    req_mem,
    input  logic [48*NUM_PE-1:0] req_mem_addr,
    output logic [NUM_PE-1:0]    req_almost_full,
    output logic [NUM_PE-1:0]    rsp_mem_push,
    output logic [63:0]          rsp_mem_q,
    output logic                 mc_req,
    output logic [47:0]          mc_req_addr,
    input  logic                 mc_req_stall,
    input  logic                 mc_rsp_push,
    input  logic [63:0]          mc_rsp_q,
    output logic                 error
);
    localparam int QAW = $clog2(REQ_BUF_DEPTH);
    localparam int TAW = $clog2(TAG_FIFO_DEPTH);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ARB  = 1'b1;
    localparam logic [QAW:0] Q_FULL = (QAW+1)'(REQ_BUF_DEPTH);
    localparam logic [QAW:0] AF_LVL =
        (QAW+1)'(REQ_BUF_DEPTH - REQ_ALMOST_FULL_SLACK);
    localparam logic [TAW:0] T_FULL = (TAW+1)'(TAG_FIFO_DEPTH);

    logic [47:0]            q_mem [NUM_PE][REQ_BUF_DEPTH];
    logic [QAW-1:0]         q_wr [NUM_PE];
    logic [QAW-1:0]         q_rd [NUM_PE];
    logic [QAW:0]           q_cnt [NUM_PE];
    logic [QAW:0]           q_cnt_n [NUM_PE];
    logic [NUM_PE-1:0]      q_ne, q_ne_n, q_full, q_push, q_pop;

    logic [LOG2_NUM_PE-1:0] tag_mem [TAG_FIFO_DEPTH];
    logic [TAW-1:0]         tag_wr, tag_rd;
    logic [TAW:0]           tag_cnt;
    logic                   tag_pop, tag_full, tag_empty;

    logic [0:0]             state, state_n;
    logic [LOG2_NUM_PE-1:0] last_grant, win, idx;
    logic                   found, issue, err_n;

    // Search starts just past the last winner; k = NUM_PE wraps onto it.
    always_comb begin
        win   = last_grant;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_PE; k++) begin
            idx = last_grant + LOG2_NUM_PE'(k);
            if (!found && q_ne[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    // A same-cycle response frees a tag slot before the issue needs one.
    always_comb begin
        tag_empty = tag_cnt == '0;
        tag_full  = tag_cnt == T_FULL;
        tag_pop   = mc_rsp_push && !tag_empty;
        issue     = (state == ARB) && found && !mc_req_stall
                    && (!tag_full || tag_pop);
        for (int i = 0; i < NUM_PE; i++) begin
            q_ne[i]    = q_cnt[i] != '0;
            q_full[i]  = q_cnt[i] == Q_FULL;
            q_push[i]  = req_mem[i] && !q_full[i];
            q_pop[i]   = issue && (win == LOG2_NUM_PE'(i));
            q_cnt_n[i] = q_cnt[i] + (QAW+1)'(q_push[i])
                         - (QAW+1)'(q_pop[i]);
            q_ne_n[i]  = q_cnt_n[i] != '0;
        end
        state_n = (|q_ne_n) ? ARB : IDLE;
        err_n   = error | (|(req_mem & q_full))
                  | (mc_rsp_push && tag_empty);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PE; i++)
            if (q_push[i])
                q_mem[i][q_wr[i]] <= req_mem_addr[48*i +: 48];
        if (issue)
            tag_mem[tag_wr] <= win;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_PE; i++) begin
                q_wr[i]  <= '0;
                q_rd[i]  <= '0;
                q_cnt[i] <= '0;
            end
            tag_wr          <= '0;
            tag_rd          <= '0;
            tag_cnt         <= '0;
            state           <= IDLE;
            last_grant      <= LOG2_NUM_PE'(NUM_PE - 1);
            mc_req          <= 1'b0;
            mc_req_addr     <= '0;
            rsp_mem_push    <= '0;
            rsp_mem_q       <= '0;
            req_almost_full <= '0;
            error           <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_PE; i++) begin
                if (q_push[i])
                    q_wr[i] <= q_wr[i] + QAW'(1);
                if (q_pop[i])
                    q_rd[i] <= q_rd[i] + QAW'(1);
                q_cnt[i]           <= q_cnt_n[i];
                req_almost_full[i] <= q_cnt_n[i] >= AF_LVL;
            end
            state  <= state_n;
            mc_req <= issue;
            if (issue) begin
                last_grant  <= win;
                mc_req_addr <= q_mem[win][q_rd[win]];
                tag_wr      <= tag_wr + TAW'(1);
            end
            if (tag_pop) begin
                tag_rd       <= tag_rd + TAW'(1);
                rsp_mem_push <= NUM_PE'(1) << tag_mem[tag_rd];
                rsp_mem_q    <= mc_rsp_q;
            end else begin
                rsp_mem_push <= '0;
            end
            tag_cnt <= tag_cnt + (TAW+1)'(issue) - (TAW+1)'(tag_pop);
            error   <= err_n;
        end
    end
endmodule

// File: tb/tb_x_req_arbiter.sv
// tb_x_req_arbiter: randomized and directed scenarios checked against a
// queue-based reference model of the arbiter.
module tb_x_req_arbiter;
    localparam int N     = 4;
    localparam int DEPTH = 8;
    localparam int SLACK = 4;
    localparam int TAGS  = 512;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_mem = '0;
    logic [48*N-1:0] req_mem_addr = '0;
    logic [N-1:0]   req_almost_full;
    logic [N-1:0]   rsp_mem_push;
    logic [63:0]    rsp_mem_q;
    logic           mc_req;
    logic [47:0]    mc_req_addr;
    logic           mc_req_stall = 1'b0;
    logic           mc_rsp_push = 1'b0;
    logic [63:0]    mc_rsp_q = '0;
    logic           error;

    x_req_arbiter #(
        .NUM_PE(N), .LOG2_NUM_PE(2), .REQ_BUF_DEPTH(DEPTH),
        .REQ_ALMOST_FULL_SLACK(SLACK), .TAG_FIFO_DEPTH(TAGS)
    ) dut (
        .clk(clk), .rst(rst),
        .req_mem(req_mem), .req_mem_addr(req_mem_addr),
        .req_almost_full(req_almost_full),
        .rsp_mem_push(rsp_mem_push), .rsp_mem_q(rsp_mem_q),
        .mc_req(mc_req), .mc_req_addr(mc_req_addr),
        .mc_req_stall(mc_req_stall),
        .mc_rsp_push(mc_rsp_push), .mc_rsp_q(mc_rsp_q),
        .error(error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: address queues, outstanding-id queue, last winner.
    logic [47:0] mq [N][$];
    int          tq [$];
    int          last;
    logic        m_req, m_err;
    logic [47:0] m_addr;
    logic [N-1:0] m_push, m_af;
    logic [63:0] m_q;

    task automatic model_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        tq.delete();
        last = N - 1;
        m_req = 0; m_err = 0; m_addr = '0;
        m_push = '0; m_af = '0; m_q = '0;
    endtask

    task automatic tick();
        int pre [N];
        int w, h;
        @(posedge clk);
        for (int i = 0; i < N; i++) pre[i] = mq[i].size();
        m_push = '0;
        if (mc_rsp_push) begin
            if (tq.size() > 0) begin
                h = tq.pop_front();
                m_push[h] = 1'b1;
                m_q = mc_rsp_q;
            end else m_err = 1'b1;
        end
        w = -1;
        for (int k = 1; k <= N; k++)
            if (w < 0 && pre[(last + k) % N] > 0) w = (last + k) % N;
        m_req = 1'b0;
        if (w >= 0 && !mc_req_stall && tq.size() < TAGS) begin
            m_addr = mq[w].pop_front();
            tq.push_back(w);
            last = w;
            m_req = 1'b1;
        end
        for (int i = 0; i < N; i++)
            if (req_mem[i]) begin
                if (pre[i] < DEPTH) mq[i].push_back(req_mem_addr[48*i +: 48]);
                else m_err = 1'b1;
            end
        for (int i = 0; i < N; i++) m_af[i] = mq[i].size() >= DEPTH - SLACK;
        #1;
    endtask

    task automatic do_reset();
        req_mem = '0; mc_req_stall = 0; mc_rsp_push = 0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        req_mem = '0; mc_req_stall = 0; mc_rsp_push = 0;
        #2 rst = 1'b0;
        #1;
        if ({mc_req, rsp_mem_push, req_almost_full, error} !== '0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0",
                     {mc_req, rsp_mem_push, req_almost_full, error});
        end
        checks++;
        if (mc_req_addr !== '0 || rsp_mem_q !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h/%h expected 0/0",
                     mc_req_addr, rsp_mem_q);
        end
        checks++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
        repeat (3) begin
            tick();
            if (mc_req !== 1'b0 || error !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle: got req=%b err=%b expected 0/0",
                         mc_req, error);
            end
            checks++;
        end
    endtask

    task automatic test_single();
        do_reset();
        req_mem = 4'b0100;
        req_mem_addr[96 +: 48] = 48'h1000;
        for (int c = 1; c <= 11; c++) begin
            tick();
            req_mem = '0;
            mc_rsp_push = 0;
            if (c == 2 && (mc_req !== 1'b1 || mc_req_addr !== 48'h1000)) begin
                errors++;
                $display("FAIL single_req: got %b/%h expected 1/1000",
                         mc_req, mc_req_addr);
            end
            if (c == 2) checks++;
            if (c == 11 && (rsp_mem_push !== 4'b0100 || rsp_mem_q !== 64'hDEAD)) begin
                errors++;
                $display("FAIL single_rsp: got %b/%h expected 0100/dead",
                         rsp_mem_push, rsp_mem_q);
            end
            if (c == 11) checks++;
            if (mc_req !== m_req || rsp_mem_push !== m_push) begin
                errors++;
                $display("FAIL single_model: got %b/%b expected %b/%b",
                         mc_req, rsp_mem_push, m_req, m_push);
            end
            checks++;
            if (c == 10) begin
                mc_rsp_push = 1;
                mc_rsp_q = 64'hDEAD;
            end
        end
    endtask

    task automatic test_round_robin();
        logic [47:0] got [$];
        logic [47:0] exp_a;
        int first = -1;
        int lastc = -1;
        do_reset();
        for (int c = 0; c < 24; c++) begin
            req_mem = '0;
            if (c < 4)
                for (int i = 0; i < N; i++) begin
                    req_mem[i] = 1'b1;
                    req_mem_addr[48*i +: 48] = 48'(i * 'h100 + c);
                end
            tick();
            if (mc_req) begin
                got.push_back(mc_req_addr);
                if (first < 0) first = c;
                lastc = c;
            end
            if (mc_req !== m_req || (m_req && mc_req_addr !== m_addr)
                || req_almost_full !== m_af) begin
                errors++;
                $display("FAIL rr_model: got %b/%h/%b expected %b/%h/%b",
                         mc_req, mc_req_addr, req_almost_full,
                         m_req, m_addr, m_af);
            end
            checks++;
        end
        req_mem = '0;
        if (got.size() != 16 || lastc - first != 15) begin
            errors++;
            $display("FAIL rr_count: got %0d over %0d cycles expected 16/16",
                     got.size(), lastc - first + 1);
        end
        checks++;
        for (int j = 0; j < 16 && j < got.size(); j++) begin
            exp_a = 48'((j % 4) * 'h100 + j / 4);
            if (got[j] !== exp_a) begin
                errors++;
                $display("FAIL rr_order[%0d]: got %h expected %h", j, got[j], exp_a);
            end
            checks++;
        end
        for (int j = 0; j < 16; j++) begin
            mc_rsp_push = 1;
            mc_rsp_q = 64'(j + 'hA0);
            tick();
            if (rsp_mem_push !== 4'(1 << (j % 4)) || rsp_mem_q !== 64'(j + 'hA0)) begin
                errors++;
                $display("FAIL rr_route[%0d]: got %b/%h expected %b/%h", j,
                         rsp_mem_push, rsp_mem_q, 4'(1 << (j % 4)), 64'(j + 'hA0));
            end
            checks++;
        end
        mc_rsp_push = 0;
        tick();
    endtask

    task automatic test_stall_af();
        int cnt;
        do_reset();
        mc_req_stall = 1;
        for (int c = 0; c < 20; c++) begin
            req_mem = (c < 5) ? 4'b0010 : 4'b0000;
            req_mem_addr[48 +: 48] = {16'h0, $urandom};
            tick();
            if ((c == 2 || c == 3) && req_almost_full[1] !== (c == 3)) begin
                errors++;
                $display("FAIL af_assert: got %b after push %0d expected %b",
                         req_almost_full[1], c + 1, c == 3);
            end
            if (c == 2 || c == 3) checks++;
            if (mc_req !== m_req || req_almost_full !== m_af) begin
                errors++;
                $display("FAIL stall_model: got %b/%b expected %b/%b",
                         mc_req, req_almost_full, m_req, m_af);
            end
            checks++;
        end
        req_mem = '0;
        mc_req_stall = 0;
        cnt = 0;
        repeat (12) begin
            tick();
            cnt += int'(mc_req);
            if (mc_req !== m_req || (m_req && mc_req_addr !== m_addr)) begin
                errors++;
                $display("FAIL stall_drain: got %b/%h expected %b/%h",
                         mc_req, mc_req_addr, m_req, m_addr);
            end
            checks++;
        end
        if (cnt != 5) begin
            errors++;
            $display("FAIL stall_count: got %0d expected 5", cnt);
        end
        checks++;
        mc_req_stall = 1;
        for (int c = 0; c < 3; c++) begin
            req_mem = 4'b0010;
            req_mem_addr[48 +: 48] = 48'(c + 'h77);
            tick();
        end
        req_mem = '0;
        mc_req_stall = 0;
        tick();
        mc_req_stall = 1;
        cnt = int'(mc_req);
        repeat (5) begin
            tick();
            cnt += int'(mc_req);
        end
        if (cnt != 1 || mq[1].size() != 2) begin
            errors++;
            $display("FAIL stall_reraise: got %0d requests expected 1", cnt);
        end
        checks++;
        mc_req_stall = 0;
        repeat (4) tick();
    endtask

    task automatic test_overflow();
        logic [47:0] pushed [$];
        logic [47:0] got [$];
        do_reset();
        mc_req_stall = 1;
        for (int c = 0; c < 9; c++) begin
            req_mem = 4'b0001;
            req_mem_addr[0 +: 48] = 48'('h5000 + c * 8);
            pushed.push_back(req_mem_addr[0 +: 48]);
            tick();
            if (c >= 7 && error !== (c == 8)) begin
                errors++;
                $display("FAIL ovf_error: got %b after push %0d expected %b",
                         error, c + 1, c == 8);
            end
            if (c >= 7) checks++;
        end
        req_mem = '0;
        tick();
        mc_req_stall = 0;
        repeat (14) begin
            tick();
            if (mc_req) got.push_back(mc_req_addr);
            if (mc_req !== m_req || error !== m_err) begin
                errors++;
                $display("FAIL ovf_model: got %b/%b expected %b/%b",
                         mc_req, error, m_req, m_err);
            end
            checks++;
        end
        if (got.size() != 8) begin
            errors++;
            $display("FAIL ovf_count: got %0d expected 8", got.size());
        end
        checks++;
        for (int j = 0; j < 8 && j < got.size(); j++) begin
            if (got[j] !== pushed[j]) begin
                errors++;
                $display("FAIL ovf_addr[%0d]: got %h expected %h", j, got[j], pushed[j]);
            end
            checks++;
        end
    endtask

    task automatic test_tag_full();
        int pushed = 0;
        int c = 0;
        int r, nrsp;
        do_reset();
        while ((tq.size() < TAGS || pushed < TAGS + 1) && c < 3000) begin
            r = c % N;
            req_mem = '0;
            if (pushed < TAGS + 1 && mq[r].size() < SLACK) begin
                req_mem[r] = 1'b1;
                req_mem_addr[48*r +: 48] = {16'h0, $urandom};
                pushed++;
            end
            tick();
            c++;
            if (mc_req !== m_req || (m_req && mc_req_addr !== m_addr)) begin
                errors++;
                $display("FAIL fill_model: got %b/%h expected %b/%h",
                         mc_req, mc_req_addr, m_req, m_addr);
            end
            checks++;
        end
        req_mem = '0;
        if (c >= 3000) begin
            errors++;
            $display("FAIL fill_timeout: got %0d tags expected %0d", tq.size(), TAGS);
        end
        checks++;
        tick();
        repeat (4) begin
            tick();
            if (mc_req !== 1'b0) begin
                errors++;
                $display("FAIL tag_full_block: got mc_req=%b expected 0", mc_req);
            end
            checks++;
        end
        mc_rsp_push = 1;
        mc_rsp_q = 64'h1234;
        tick();
        mc_rsp_push = 0;
        if (mc_req !== 1'b1 || mc_req_addr !== m_addr || rsp_mem_push !== m_push) begin
            errors++;
            $display("FAIL simul_issue: got %b/%h/%b expected 1/%h/%b",
                     mc_req, mc_req_addr, rsp_mem_push, m_addr, m_push);
        end
        checks++;
        nrsp = 1;
        for (int j = 0; j < TAGS; j++) begin
            mc_rsp_push = 1;
            mc_rsp_q = {$urandom, $urandom};
            tick();
            nrsp += int'(rsp_mem_push != '0);
            if (rsp_mem_push !== m_push || rsp_mem_q !== m_q || mc_req !== 1'b0) begin
                errors++;
                $display("FAIL drain_route: got %b/%h expected %b/%h",
                         rsp_mem_push, rsp_mem_q, m_push, m_q);
            end
            checks++;
        end
        if (nrsp != TAGS + 1 || error !== 1'b0) begin
            errors++;
            $display("FAIL drain_count: got %0d err=%b expected %0d err=0",
                     nrsp, error, TAGS + 1);
        end
        checks++;
        tick();
        mc_rsp_push = 0;
        if (error !== 1'b1 || rsp_mem_push !== '0) begin
            errors++;
            $display("FAIL empty_rsp: got err=%b push=%b expected 1/0000",
                     error, rsp_mem_push);
        end
        checks++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            req_mem = 4'($urandom_range(1, 15)) & ~m_af;
            for (int i = 0; i < N; i++)
                req_mem_addr[48*i +: 48] = {16'h1, $urandom | 1};
            mc_rsp_push = tq.size() > 0;
            mc_rsp_q = {$urandom, $urandom};
            tick();
        end
        req_mem = '0; mc_rsp_push = 0;
        #3 rst = 1'b0;
        #1;
        if ({mc_req, rsp_mem_push, req_almost_full, error} !== '0
            || mc_req_addr !== '0 || rsp_mem_q !== '0) begin
            errors++;
            $display("FAIL midrst_zero: got %b %h %h expected all 0",
                     {mc_req, rsp_mem_push, req_almost_full, error},
                     mc_req_addr, rsp_mem_q);
        end
        checks++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
        req_mem = '1;
        for (int i = 0; i < N; i++)
            req_mem_addr[48*i +: 48] = 48'('hA00 + i);
        for (int c = 1; c <= 5; c++) begin
            tick();
            req_mem = '0;
            if (c >= 2 && (mc_req !== 1'b1 || mc_req_addr !== 48'('hA00 + c - 2))) begin
                errors++;
                $display("FAIL midrst_arb: got %b/%h expected 1/%h",
                         mc_req, mc_req_addr, 48'('hA00 + c - 2));
            end
            if (c >= 2) checks++;
            if (c == 1 && mc_req !== 1'b0) begin
                errors++;
                $display("FAIL midrst_lat: got %b expected 0", mc_req);
            end
            if (c == 1) checks++;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req_mem = '0;
            for (int i = 0; i < N; i++)
                if (mq[i].size() < DEPTH - 2 && $urandom_range(0, 99) < 35) begin
                    req_mem[i] = 1'b1;
                    req_mem_addr[48*i +: 48] = {16'($urandom), $urandom};
                end
            mc_req_stall = $urandom_range(0, 99) < 30;
            mc_rsp_push = tq.size() > 0 && $urandom_range(0, 99) < 40;
            mc_rsp_q = {$urandom, $urandom};
            tick();
            if (mc_req !== m_req || (m_req && mc_req_addr !== m_addr)) begin
                errors++;
                $display("FAIL rand_mc: got %b/%h expected %b/%h",
                         mc_req, mc_req_addr, m_req, m_addr);
            end
            checks++;
            if (rsp_mem_push !== m_push || (m_push != 0 && rsp_mem_q !== m_q)) begin
                errors++;
                $display("FAIL rand_rsp: got %b/%h expected %b/%h",
                         rsp_mem_push, rsp_mem_q, m_push, m_q);
            end
            checks++;
            if (req_almost_full !== m_af || error !== m_err) begin
                errors++;
                $display("FAIL rand_flags: got %b/%b expected %b/%b",
                         req_almost_full, error, m_af, m_err);
            end
            checks++;
        end
        req_mem = '0; mc_req_stall = 0; mc_rsp_push = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_stall_af();
        test_overflow();
        test_tag_full();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/x_req_arbiter.md
# x_req_arbiter

Shares one memory-controller request/response port among NUM_PE x-vector request streams (one per PE's x-vector cache). Each requester's fire-and-forget read requests are buffered in a small per-requester queue. Queues are served round-robin onto the single memory port, and in-order read responses are routed back to the requester that issued them. It sits between the PE x-vector caches and the shared memory-controller port, and sequences all x-vector traffic on that port.

## Interface
- NUM_PE, 4: number of requesters; power of two, 2..16.
- LOG2_NUM_PE, 2: log2(NUM_PE).
- REQ_BUF_DEPTH, 8: entries per requester queue; power of two ≥ 8.
- REQ_ALMOST_FULL_SLACK, 4: free entries remaining at which req_almost_full asserts.
- TAG_FIFO_DEPTH, 512: maximum outstanding memory reads; power of two.

- clk  in  1  sole clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_mem  in  NUM_PE  per-requester read request pulse, one request per cycle per requester.
- req_mem_addr  in  48*NUM_PE  byte address; requester i uses bits [48i+47:48i].
- req_almost_full  out  NUM_PE  requester i must stop issuing new requests.
- rsp_mem_push  out  NUM_PE  one-cycle pulse delivering a response to requester i.
- rsp_mem_q  out  64  response data, shared by all requesters, valid with any rsp_mem_push bit.
- mc_req  out  1  memory read request valid.
- mc_req_addr  out  48  memory read address.
- mc_req_stall  in  1  memory port cannot accept a request this cycle.
- mc_rsp_push  in  1  memory response valid; responses return in request order.
- mc_rsp_q  in  64  memory response data.
- error  out  1  sticky error flag: overflow or unexpected response.

## Operation
- **Per-requester queue i:** FIFO of 48-bit addresses.
  - Push when req_mem[i]=1.
  - A push while full is dropped and sets error.
  - A push and a pop in the same cycle leave the count unchanged.
- **req_almost_full[i]:** registered; asserted when count_i ≥ REQ_BUF_DEPTH − REQ_ALMOST_FULL_SLACK. The slack absorbs the requester's 3-cycle request pipeline.
- **Issue condition:** an issue occurs in a cycle when all of the following hold:
  - at least one queue is non-empty;
  - mc_req_stall=0;
  - the tag FIFO is not full.
- **Round-robin arbitration:**
  - 2-state FSM: IDLE (no queue non-empty) and ARB.
  - Register last_grant, reset value NUM_PE−1.
  - The winner is the first non-empty queue found searching last_grant+1, last_grant+2, … modulo NUM_PE.
  - On issue: the winner's queue pops, last_grant becomes the winner, and the winner index is pushed into the tag FIFO.
  - With no issue, last_grant holds.
- **Tag FIFO:** stores LOG2_NUM_PE-bit requester ids in issue order; one entry is outstanding per memory read.
- **Response routing:**
  - On mc_rsp_push=1 with the tag FIFO non-empty: pop the head id h; next cycle rsp_mem_push[h]=1 and rsp_mem_q=mc_rsp_q.
  - On mc_rsp_push=1 with the tag FIFO empty: the response is discarded and error is set.
- **Simultaneous issue and response** (including with the tag FIFO full): the response pop happens first, so the issue is permitted and the occupancy is unchanged.
- **error:** cleared only by reset.

## Timing
- **Reset values (rst low, asynchronous):**
  - mc_req=0, mc_req_addr=0
  - rsp_mem_push=0, rsp_mem_q=0
  - req_almost_full=0, error=0
  - all queues and the tag FIFO empty; FSM in IDLE.
- **Request path latency:** req_mem[i] at cycle t, with queue i previously empty, no competitors and no stall, produces mc_req=1 at t+2 carrying that address.
  - t+1: the entry becomes visible at the queue head.
  - Grant is decided combinationally in the cycle the issue condition holds.
  - mc_req and mc_req_addr are registered one cycle after the grant.
- **mc_req_stall:** sampled in the grant cycle; it blocks the grant and does not retract an already-registered mc_req. Consequently, the memory port must tolerate one request arriving after it raises stall.
- **Throughput:** at most one mc_req per cycle; sustained 1/cycle while the issue condition holds.
- **Response path latency:** 1 cycle (mc_rsp_push at t → rsp_mem_push at t+1).
- **req_almost_full:** updates one cycle after the count change.

## Test plan
- **Single request:** reset, then req_mem[2]=1 with addr 0x1000 at t0 → mc_req=1 with addr 0x1000 at t0+2. Then mc_rsp_push with data 0xDEAD at t0+10 → rsp_mem_push=4'b0100 with rsp_mem_q=0xDEAD at t0+11.
- **Round robin, all requesters every cycle:** all four requesters push every cycle for 4 cycles, addresses i*0x100+k (k = cycle index 0..3), no stall → mc_req addresses in order 0x000, 0x100, 0x200, 0x300, 0x001, … over 16 consecutive cycles. Returned responses are routed to requesters 0, 1, 2, 3, 0, ….
- **Stall and almost-full:** hold mc_req_stall=1 for 20 cycles while requester 1 pushes 5 requests → req_almost_full[1]=1 one cycle after the 4th push. After release, exactly 5 mc_req go out, with at most one extra beyond a re-raised stall.
- **Overflow:** push 9 requests into requester 0 under stall → error=1 from the cycle after the 9th push. Only 8 addresses are issued after release.
- **Full tag FIFO, simultaneous events:**
  - Issue 512 reads with no responses → no 513th mc_req.
  - Assert mc_rsp_push in the same cycle as a pending request → that request issues, and occupancy stays at 512.
  - Response with the tag FIFO empty → error=1, and no rsp_mem_push bit is set.
- **Mid-operation reset:** assert rst low mid-traffic → all outputs are 0 immediately. After release, the first request follows the single-request timing, and arbitration starts from requester 0.
